// File: rtl/blu_pkg.sv
// rtl/blu_pkg.sv - shared opcode enum, queue depth and bitwise compute function for bitwise_logic_unit
package blu_pkg;

  typedef enum logic [2:0] {
    BLU_AND    = 3'd0,
    BLU_OR     = 3'd1,
    BLU_XOR    = 3'd2,
    BLU_NAND   = 3'd3,
    BLU_NOR    = 3'd4,
    BLU_XNOR   = 3'd5,
    BLU_ANDN   = 3'd6,
    BLU_PASS_A = 3'd7
  } blu_op_e;

  localparam int QUEUE_DEPTH = 2;

  // Single-bit form keeps the function width-agnostic; callers loop over WIDTH.
  function automatic logic blu_compute_bit(input blu_op_e op, input logic a, input logic b);
    logic r;
    case (op)
      BLU_AND:    r = a & b;
      BLU_OR:     r = a | b;
      BLU_XOR:    r = a ^ b;
      BLU_NAND:   r = ~(a & b);
      BLU_NOR:    r = ~(a | b);
      BLU_XNOR:   r = ~(a ^ b);
      BLU_ANDN:   r = a & ~b;
      default:    r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/blu_popcount.sv
// rtl/blu_popcount.sv - combinational population count of a WIDTH-bit word
module blu_popcount #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// rtl/bitwise_logic_unit.sv - bitwise op unit with accumulator and 2-entry result queue; BLU_POPCOUNT_EN adds out_popcnt
module bitwise_logic_unit
  import blu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [WIDTH-1:0] acc_q
`ifdef BLU_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] out_popcnt
`endif
);

  logic [WIDTH-1:0] q_data [QUEUE_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] result;
  logic             push;
  logic             pop;

  // A clear arriving with an accumulating op makes that op start from zero.
  assign acc_eff = acc_clr ? '0 : acc_q;
  assign op_a    = in_acc ? acc_eff : in_a;

  always_comb begin
    result = '0;
    for (int i = 0; i < WIDTH; i++) begin
      result[i] = blu_compute_bit(blu_op_e'(in_op), op_a[i], in_b[i]);
    end
  end

  assign in_ready  = (count != 2'(QUEUE_DEPTH));
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data  = q_data[rd_ptr];
  assign out_zero  = (out_data == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_data[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        q_data[wr_ptr] <= result;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (push && in_acc) begin
      acc_q <= result;
    end else if (acc_clr) begin
      acc_q <= '0;
    end
  end

`ifdef BLU_POPCOUNT_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] result_cnt;
  logic [CNT_W-1:0] q_cnt [QUEUE_DEPTH];

  blu_popcount #(.WIDTH(WIDTH)) u_popcount (
    .data  (result),
    .count (result_cnt)
  );

  // Counted at push time so the output path is a plain register read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_cnt[i] <= '0;
      end
    end else if (push) begin
      q_cnt[wr_ptr] <= result_cnt;
    end
  end

  assign out_popcnt = q_cnt[rd_ptr];
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// tb/tb_bitwise_logic_unit.sv - self-checking bench for bitwise_logic_unit against a queue-based reference model
module tb_bitwise_logic_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       in_acc;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_zero;
  logic [7:0] acc_q;
`ifdef BLU_POPCOUNT_EN
  logic [3:0] out_popcnt;
`endif

  int passed = 0;
  int total  = 0;

  bit [7:0] mq[$];
  bit [7:0] macc;

  bitwise_logic_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .acc_q     (acc_q)
`ifdef BLU_POPCOUNT_EN
    ,
    .out_popcnt(out_popcnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit [7:0] ref_op(input int op, input bit [7:0] a, input bit [7:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return ~(a ^ b);
      6: return a & ~b;
      default: return a;
    endcase
  endfunction

  // Advance one clock, updating the reference model from the inputs applied.
  task automatic drive_cycle();
    bit [7:0] a;
    bit [7:0] r;
    bit       push;
    bit       pop;
    if (!rst_n) begin
      @(posedge clk); #1;
      mq.delete();
      macc = 8'h00;
      return;
    end
    a    = in_acc ? (acc_clr ? 8'h00 : macc) : in_a;
    r    = ref_op(int'(in_op), a, in_b);
    push = in_valid && (mq.size() < 2);
    pop  = (mq.size() != 0) && out_ready;
    @(posedge clk); #1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(r);
    if (push && in_acc) macc = r;
    else if (acc_clr) macc = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h3C; in_op = 3'd1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle();
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid cyc=%0d got %b want 0", i, out_valid); else passed++;
      total++; if (out_zero !== 1'b1) $display("FAIL reset_out_zero cyc=%0d got %b want 1", i, out_zero); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready cyc=%0d got %b want 1", i, in_ready); else passed++;
      total++; if (acc_q !== 8'h00) $display("FAIL reset_acc_q cyc=%0d got %h want 00", i, acc_q); else passed++;
      total++; if (out_data !== 8'h00) $display("FAIL reset_out_data cyc=%0d got %h want 00", i, out_data); else passed++;
    end
    rst_n = 1'b1; in_op = 3'd0; in_a = 8'hFF; in_b = 8'h3C; out_ready = 1'b1;
    drive_cycle();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL first_xfer_valid got %b want 1", out_valid); else passed++;
    total++; if (out_data !== 8'h3C) $display("FAIL first_xfer_data got %h want 3c", out_data); else passed++;
    drive_cycle();
  endtask

  task automatic test_all_ops();
    bit [7:0] exp_tab [8] = '{8'h4A, 8'hDF, 8'h95, 8'hB5, 8'h20, 8'h6A, 8'h80, 8'hCA};
    out_ready = 1'b1; in_acc = 1'b0; acc_clr = 1'b0;
    in_a = 8'hCA; in_b = 8'h5F; in_valid = 1'b1;
    for (int op = 0; op < 8; op++) begin
      in_op = 3'(op);
      drive_cycle();
      total++; if (out_valid !== 1'b1) $display("FAIL ops_valid op=%0d got %b want 1", op, out_valid); else passed++;
      total++; if (out_data !== exp_tab[op]) $display("FAIL ops_data op=%0d got %h want %h", op, out_data, exp_tab[op]); else passed++;
      total++; if (out_zero !== 1'b0) $display("FAIL ops_zero op=%0d got %b want 0", op, out_zero); else passed++;
    end
    in_valid = 1'b0;
    drive_cycle();
    total++; if (out_valid !== 1'b0) $display("FAIL ops_drain got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_backpressure();
    bit [7:0] a [3];
    bit [7:0] b [3];
    bit [2:0] o [3];
    bit [7:0] e [3];
    for (int i = 0; i < 3; i++) begin
      a[i] = 8'($urandom); b[i] = 8'($urandom); o[i] = 3'($urandom_range(0, 6));
      e[i] = ref_op(int'(o[i]), a[i], b[i]);
    end
    out_ready = 1'b0; in_acc = 1'b0; in_valid = 1'b1;
    in_a = a[0]; in_b = b[0]; in_op = o[0];
    drive_cycle();
    total++; if (in_ready !== 1'b1) $display("FAIL bp_ready1 got %b want 1", in_ready); else passed++;
    total++; if (out_data !== e[0]) $display("FAIL bp_head1 got %h want %h", out_data, e[0]); else passed++;
    in_a = a[1]; in_b = b[1]; in_op = o[1];
    drive_cycle();
    total++; if (in_ready !== 1'b0) $display("FAIL bp_full got %b want 0", in_ready); else passed++;
    total++; if (out_data !== e[0]) $display("FAIL bp_head2 got %h want %h", out_data, e[0]); else passed++;
    in_a = a[2]; in_b = b[2]; in_op = o[2];
    drive_cycle();
    total++; if (in_ready !== 1'b0) $display("FAIL bp_still_full got %b want 0", in_ready); else passed++;
    total++; if (out_data !== e[0]) $display("FAIL bp_hold got %h want %h", out_data, e[0]); else passed++;
    out_ready = 1'b1;
    drive_cycle();
    total++; if (in_ready !== 1'b1) $display("FAIL bp_reopen got %b want 1", in_ready); else passed++;
    total++; if (out_data !== e[1]) $display("FAIL bp_second got %h want %h", out_data, e[1]); else passed++;
    drive_cycle();
    in_valid = 1'b0;
    total++; if (out_data !== e[2]) $display("FAIL bp_third got %h want %h", out_data, e[2]); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL bp_third_valid got %b want 1", out_valid); else passed++;
    drive_cycle();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_accumulate();
    bit [7:0] bs  [3] = '{8'h01, 8'h02, 8'h04};
    bit [7:0] exp [3] = '{8'h01, 8'h03, 8'h07};
    out_ready = 1'b1; in_valid = 1'b0; acc_clr = 1'b1;
    drive_cycle();
    acc_clr = 1'b0;
    total++; if (acc_q !== 8'h00) $display("FAIL acc_cleared got %h want 00", acc_q); else passed++;
    in_acc = 1'b1; in_op = 3'd1; in_a = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_b = bs[i];
      drive_cycle();
      total++; if (out_data !== exp[i]) $display("FAIL acc_chain_data step=%0d got %h want %h", i, out_data, exp[i]); else passed++;
      total++; if (acc_q !== exp[i]) $display("FAIL acc_chain_acc step=%0d got %h want %h", i, acc_q, exp[i]); else passed++;
    end
    in_valid = 1'b0; in_acc = 1'b0;
    drive_cycle();
  endtask

  task automatic test_acc_clr_coincident();
    out_ready = 1'b1;
    in_valid = 1'b1; in_acc = 1'b1; acc_clr = 1'b1; in_op = 3'd1; in_b = 8'hF0;
    drive_cycle();
    total++; if (acc_q !== 8'hF0) $display("FAIL accclr_setup got %h want f0", acc_q); else passed++;
    in_op = 3'd2; in_b = 8'h0F;
    drive_cycle();
    total++; if (out_data !== 8'h0F) $display("FAIL accclr_xor_data got %h want 0f", out_data); else passed++;
    total++; if (acc_q !== 8'h0F) $display("FAIL accclr_xor_acc got %h want 0f", acc_q); else passed++;
    acc_clr = 1'b0; in_acc = 1'b0; in_op = 3'd0; in_a = 8'hF0; in_b = 8'h0F;
    drive_cycle();
    total++; if (out_zero !== 1'b1) $display("FAIL zero_flag got %b want 1", out_zero); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL zero_data got %h want 00", out_data); else passed++;
    total++; if (acc_q !== 8'h0F) $display("FAIL zero_acc_kept got %h want 0f", acc_q); else passed++;
    acc_clr = 1'b1; in_op = 3'd1; in_a = 8'h12; in_b = 8'h34;
    drive_cycle();
    total++; if (out_data !== 8'h36) $display("FAIL clr_plain_data got %h want 36", out_data); else passed++;
    total++; if (acc_q !== 8'h00) $display("FAIL clr_plain_acc got %h want 00", acc_q); else passed++;
    acc_clr = 1'b0; in_valid = 1'b0;
    drive_cycle();
  endtask

  task automatic test_midreset();
    out_ready = 1'b0; in_valid = 1'b1; in_acc = 1'b1; in_op = 3'd1; in_b = 8'h81;
    drive_cycle();
    drive_cycle();
    total++; if (in_ready !== 1'b0) $display("FAIL midrst_full got %b want 0", in_ready); else passed++;
    rst_n = 1'b0;
    drive_cycle();
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", in_ready); else passed++;
    total++; if (acc_q !== 8'h00) $display("FAIL midrst_acc got %h want 00", acc_q); else passed++;
    rst_n = 1'b1; in_valid = 1'b0; in_acc = 1'b0;
    drive_cycle();
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_after got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 60) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) < 3);
      in_acc    = ($urandom_range(0, 9) < 3);
      acc_clr   = ($urandom_range(0, 9) == 0);
      in_op     = 3'($urandom);
      in_a      = 8'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      drive_cycle();
      total++; if (in_ready !== (mq.size() < 2)) $display("FAIL rnd_in_ready i=%0d got %b want %b", i, in_ready, mq.size() < 2); else passed++;
      total++; if (out_valid !== (mq.size() != 0)) $display("FAIL rnd_out_valid i=%0d got %b want %b", i, out_valid, mq.size() != 0); else passed++;
      total++; if (acc_q !== macc) $display("FAIL rnd_acc i=%0d got %h want %h", i, acc_q, macc); else passed++;
      if (mq.size() != 0) begin
        total++; if (out_data !== mq[0]) $display("FAIL rnd_data i=%0d got %h want %h", i, out_data, mq[0]); else passed++;
        total++; if (out_zero !== (mq[0] == 8'h00)) $display("FAIL rnd_zero i=%0d got %b want %b", i, out_zero, mq[0] == 8'h00); else passed++;
`ifdef BLU_POPCOUNT_EN
        total++; if (out_popcnt !== 4'($countones(mq[0]))) $display("FAIL rnd_popcnt i=%0d got %0d want %0d", i, out_popcnt, $countones(mq[0])); else passed++;
`endif
      end
    end
    rst_n = 1'b1; in_valid = 1'b0; acc_clr = 1'b0; in_acc = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 3'd0;
    in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    mq.delete(); macc = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_all_ops();
    test_backpressure();
    test_accumulate();
    test_acc_clr_coincident();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
